vc_plane_arbiter: RTL

Time-multiplexes the crossbar switch between virtual-channel planes. It picks which VC plane's route state and flits own the switch each cycle, and drives the one-hot `VCPlaneSelector` consumed by the switch control. Arbitration is round-robin with wormhole locking: a plane keeps the switch until its packet's tail has crossed or its request drops. It sits beside the switch, fed by per-plane pending/tail indications from the input buffers.

---
 rtl/vc_plane_arbiter_if.sv | 29 ++
 rtl/vc_plane_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/vc_plane_arbiter_if.sv
// Switch-side bundle between the VC plane arbiter and the crossbar control.
// master: arbiter side; slave: input buffers and switch control.
interface vc_plane_arbiter_if #(
    parameter int VC = 4
);
    localparam int IW = (VC > 1) ? $clog2(VC) : 1;

    logic [VC-1:0] vcRequest;
    logic [VC-1:0] vcRelease;
    logic [VC:0]   VCPlaneSelector;
    logic          grantValid;
    logic [IW-1:0] grantIndex;

    modport master (
        input  vcRequest,
        input  vcRelease,
        output VCPlaneSelector,
        output grantValid,
        output grantIndex
    );

    modport slave (
        output vcRequest,
        output vcRelease,
        input  VCPlaneSelector,
        input  grantValid,
        input  grantIndex
    );
endinterface

// File: rtl/vc_plane_arbiter.sv
// Round-robin, wormhole-locked owner of the crossbar among VC planes.
// Optional VC_QUANTUM_EN bounds a grant to QUANTUM cycles under contention.
module vc_plane_arbiter #(
    parameter int VC      = 4,
    parameter int QUANTUM = 8
) (
    input logic clk,
    input logic rst,
    vc_plane_arbiter_if.master bus
);
    localparam int IW = (VC > 1) ? $clog2(VC) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    if (VC < 1) begin : g_bad_vc
        $error("VC must be >= 1");
    end
    if (QUANTUM < 1) begin : g_bad_quantum
        $error("QUANTUM must be >= 1");
    end

    logic [0:0]    state;
    logic [IW-1:0] g;
    logic [IW-1:0] ptr;
    logic [IW-1:0] pick;
    logic [IW-1:0] next_ptr;
    logic          found;
    logic          quantum_hit;
    logic          hold_end;
    logic [VC-1:0] plane_oh;
    int            cand;

    // First requester at or after ptr, wrapping at VC
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < VC; k++) begin
            cand = (int'(ptr) + k) % VC;
            if (!found && bus.vcRequest[IW'(cand)]) begin
                found = 1'b1;
                pick  = IW'(cand);
            end
        end
    end

    assign plane_oh = VC'(1) << g;
    assign next_ptr = (g == IW'(VC - 1)) ? '0 : g + 1'b1;
    assign hold_end = bus.vcRelease[g] | ~bus.vcRequest[g] | quantum_hit;

`ifdef VC_QUANTUM_EN
    localparam int QW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

    logic [QW-1:0] qcnt;
    logic [VC-1:0] others;

    assign others = bus.vcRequest & ~plane_oh;
    assign quantum_hit = (state == HOLD) &&
                         (qcnt == QW'(QUANTUM - 1)) &&
                         (|others);

    always_ff @(posedge clk) begin
        if (!rst) begin
            qcnt <= '0;
        end else if (state == IDLE) begin
            qcnt <= '0;
        end else if (qcnt != QW'(QUANTUM - 1)) begin
            qcnt <= qcnt + 1'b1;
        end
    end
`else
    assign quantum_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            g     <= '0;
            ptr   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        g     <= pick;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (hold_end) begin
                        ptr   <= next_ptr;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only
    assign bus.VCPlaneSelector = (state == HOLD) ? {1'b0, plane_oh}
                                                 : {1'b1, {VC{1'b0}}};
    assign bus.grantValid = (state == HOLD);
    assign bus.grantIndex = (state == HOLD) ? g : '0;
endmodule
